// File: rtl/core_ctrl_if.sv
// Host streaming port for core_ctrl: Q/K vectors over valid/ready.
// The master drives valid/data; the slave (sequencer) drives ready.
interface core_ctrl_if #(
    parameter int DW = 64
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/core_ctrl.sv
// Attention-pass sequencer driving core.inst / core.mem_in.
// Optional macro CORE_CTRL_KREUSE_EN adds k_reuse to skip K_WR/LOAD.
module core_ctrl #(
    parameter int bw          = 8,
    parameter int pr          = 8,
    parameter int col         = 8,
    parameter int total_cycle = 8,
    parameter int load_gap    = 10,
    parameter int exec_drain  = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef CORE_CTRL_KREUSE_EN
    input  logic             k_reuse,
`endif
    core_ctrl_if.slave       host,
    output logic [pr*bw-1:0] mem_in,
    output logic [16:0]      inst,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);
    typedef enum logic [3:0] {
        IDLE, Q_WR, K_WR, LOAD, GAP,
        EXEC, DRAIN, MOVE, READ, DONE
    } state_t;

    // 5-bit count so LOAD (col+2 cycles) still fits at col=16
    localparam logic [4:0] T_LAST = 5'(total_cycle - 1);
    localparam logic [4:0] C_LAST = 5'(col - 1);
    localparam logic [4:0] L_LAST = 5'(col + 1);
    localparam logic [4:0] G_LAST = 5'(load_gap - 1);
    localparam logic [4:0] D_LAST = 5'(exec_drain - 1);

    state_t           state, state_nx;
    logic [4:0]       cnt, cnt_nx;
    logic             rdy_q, rdy_d;
    logic [16:0]      inst_d;
    logic [pr*bw-1:0] mem_d;
    logic             busy_d, done_d;
    logic             hs, skip_k;

    assign hs            = host.in_valid & rdy_q;
    assign host.in_ready = rdy_q;

`ifdef CORE_CTRL_KREUSE_EN
    logic k_loaded, reuse_q;

    // remember a completed LOAD and latch the reuse request at start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_loaded <= 1'b0;
            reuse_q  <= 1'b0;
        end else begin
            if (state == LOAD && state_nx == GAP)
                k_loaded <= 1'b1;
            if (state == IDLE && start)
                reuse_q <= k_reuse & k_loaded;
        end
    end

    assign skip_k = reuse_q;
`else
    assign skip_k = 1'b0;
`endif

    // state and phase counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // next state; counter clears on every phase change
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE:  if (start) state_nx = Q_WR;
            Q_WR:  if (hs) begin
                       cnt_nx = cnt + 5'd1;
                       if (cnt == T_LAST)
                           state_nx = skip_k ? GAP : K_WR;
                   end
            K_WR:  if (hs) begin
                       cnt_nx = cnt + 5'd1;
                       if (cnt == C_LAST) state_nx = LOAD;
                   end
            LOAD:  begin
                       cnt_nx = cnt + 5'd1;
                       if (cnt == L_LAST) state_nx = GAP;
                   end
            GAP:   begin
                       cnt_nx = cnt + 5'd1;
                       if (cnt == G_LAST) state_nx = EXEC;
                   end
            EXEC:  begin
                       cnt_nx = cnt + 5'd1;
                       if (cnt == T_LAST) state_nx = DRAIN;
                   end
            DRAIN: begin
                       cnt_nx = cnt + 5'd1;
                       if (cnt == D_LAST) state_nx = MOVE;
                   end
            MOVE:  begin
                       cnt_nx = cnt + 5'd1;
                       if (cnt == T_LAST) state_nx = READ;
                   end
            READ:  begin
                       cnt_nx = cnt + 5'd1;
                       if (cnt == T_LAST) state_nx = DONE;
                   end
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (state_nx != state) cnt_nx = '0;
    end

    // next values of the registered outputs for the current phase cycle
    always_comb begin
        inst_d = '0;
        mem_d  = '0;
        done_d = 1'b0;
        rdy_d  = (state_nx == Q_WR) || (state_nx == K_WR);
        busy_d = (state != IDLE) || (state_nx != IDLE);
        unique case (state)
            Q_WR:  if (hs) begin
                       inst_d[4]     = 1'b1;
                       inst_d[15:12] = cnt[3:0];
                       mem_d         = host.in_data;
                   end
            K_WR:  if (hs) begin
                       inst_d[2]     = 1'b1;
                       inst_d[15:12] = cnt[3:0];
                       mem_d         = host.in_data;
                   end
            LOAD:  begin
                       inst_d[6] = 1'b1;
                       if (cnt != 5'd0 && cnt != L_LAST) begin
                           inst_d[3]     = 1'b1;
                           inst_d[15:12] = 4'(cnt - 5'd1);
                       end
                   end
            EXEC:  begin
                       inst_d[7]     = 1'b1;
                       inst_d[5]     = 1'b1;
                       inst_d[15:12] = cnt[3:0];
                   end
            MOVE:  begin
                       inst_d[16]   = 1'b1;
                       inst_d[0]    = 1'b1;
                       inst_d[11:8] = cnt[3:0];
                   end
            READ:  begin
                       inst_d[1]    = 1'b1;
                       inst_d[11:8] = cnt[3:0];
                   end
            DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // output registers; out_valid trails pmem_rd by one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst      <= '0;
            mem_in    <= '0;
            rdy_q     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            inst      <= inst_d;
            mem_in    <= mem_d;
            rdy_q     <= rdy_d;
            out_valid <= inst[1];
            busy      <= busy_d;
            done      <= done_d;
        end
    end
endmodule
